brch_ckpt_queue: RTL and testbench

- Branch checkpoint queue inside the active-list stage. Sits between dispatch (up to 4 decoded instructions per cycle) and commit/mispredict handling.
- For every dispatched branch it records the branch's active-list index and the free-list allocation position current at that branch.
- On commit it retires the oldest checkpoint. On mispredict it returns the saved free-list position for rollback and discards all younger checkpoints.

---
 rtl/brch_ckpt_queue.sv | 151 +++++++++++++++
 tb/tb_brch_ckpt_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brch_ckpt_queue.sv
// Branch checkpoint queue: one {active-list index, free-list position} entry per
// dispatched branch, retired in order on commit and truncated on mispredict.
module brch_ckpt_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_vld,
  input  logic [3:0]               brch,
  input  logic [3:0]               preg_need,
  input  logic [IDX_W-1:0]         base_indx,
  input  logic [POS_W-1:0]         curr_pos,
  input  logic                     cmt_brch,
  input  logic [IDX_W-1:0]         cmt_brch_indx,
  input  logic                     mis_pred,
  input  logic [IDX_W-1:0]         brch_mis_indx,
  output logic                     space_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     rcv_vld,
  output logic [POS_W-1:0]         rcv_pos,
  output logic                     rcv_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [IDX_W-1:0] ent_indx [DEPTH];
  logic [POS_W-1:0] ent_pos  [DEPTH];

  ptr_t head, tail, head_n, tail_n;
  cnt_t count_n;

  logic [2:0]       push_cnt;
  logic [3:0]       free_cnt;
  logic             push_en;
  logic             cmt_hit;
  logic             mis_hit;
  ptr_t             mis_off;
  logic [POS_W-1:0] mis_pos;
  logic             rcv_err_n;

  ptr_t             wr_ptr  [4];
  logic [IDX_W-1:0] wr_indx [4];
  logic [POS_W-1:0] wr_pos  [4];

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Space check deliberately ignores a same-cycle commit so it stays off the CAM path.
  assign push_cnt = pop4(brch);
  assign free_cnt = 4'(DEPTH) - 4'(count);
  assign space_ok = free_cnt >= {1'b0, push_cnt};
  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(DEPTH));
  assign push_en  = disp_vld & space_ok & ~mis_pred;

  // Slot k lands after all older branches of the group; its position skips only
  // the registers allocated by older slots.
  always_comb begin
    logic [3:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask       = 4'((5'd1 << k) - 5'd1);
      wr_ptr[k]  = tail + ptr_t'(pop4(brch & mask));
      wr_indx[k] = base_indx + IDX_W'(k);
      wr_pos[k]  = curr_pos + POS_W'(pop4(preg_need & mask));
    end
  end

  assign cmt_hit = cmt_brch & ~empty & (ent_indx[head] == cmt_brch_indx);

  // Descending scan so the smallest offset (oldest entry) is the final winner.
  always_comb begin
    mis_hit = 1'b0;
    mis_off = '0;
    for (int m = DEPTH - 1; m >= 0; m--) begin
      if ((cnt_t'(m) < count) && (ent_indx[head + ptr_t'(m)] == brch_mis_indx)) begin
        mis_hit = 1'b1;
        mis_off = ptr_t'(m);
      end
    end
  end

  assign mis_pos = ent_pos[head + mis_off];

  always_comb begin
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    if (mis_pred && mis_hit) begin
      // Flush is measured from the original head; a commit of the flushed head is dropped.
      tail_n = head + mis_off;
      if (cmt_hit && (mis_off != '0)) begin
        head_n  = head + ptr_t'(1);
        count_n = {1'b0, mis_off} - cnt_t'(1);
      end else begin
        count_n = {1'b0, mis_off};
      end
    end else begin
      if (cmt_hit) begin
        head_n  = head + ptr_t'(1);
        count_n = count_n - cnt_t'(1);
      end
      if (push_en) begin
        tail_n  = tail + ptr_t'(push_cnt);
        count_n = count_n + cnt_t'(push_cnt);
      end
    end
  end

  assign rcv_err_n = (cmt_brch & ~cmt_hit) | (mis_pred & ~mis_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rcv_vld <= 1'b0;
      rcv_pos <= '0;
      rcv_err <= 1'b0;
    end else begin
      head    <= head_n;
      tail    <= tail_n;
      count   <= count_n;
      rcv_vld <= mis_pred & mis_hit;
      rcv_err <= rcv_err_n;
      if (mis_pred && mis_hit) begin
        rcv_pos <= mis_pos;
      end
    end
  end

  // Entry payload needs no reset: occupancy is tracked solely by head/count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_en && brch[k]) begin
        ent_indx[wr_ptr[k]] <= wr_indx[k];
        ent_pos[wr_ptr[k]]  <= wr_pos[k];
      end
    end
  end

endmodule

// File: tb/tb_brch_ckpt_queue.sv
// Table-driven bench for brch_ckpt_queue with a scoreboard of expected
// post-edge outputs, plus hand sequences for wrap-around and async reset.
module tb_brch_ckpt_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_vld;
  logic [3:0] brch;
  logic [3:0] preg_need;
  logic [5:0] base_indx;
  logic [6:0] curr_pos;
  logic       cmt_brch;
  logic [5:0] cmt_brch_indx;
  logic       mis_pred;
  logic [5:0] brch_mis_indx;
  logic       space_ok;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       rcv_vld;
  logic [6:0] rcv_pos;
  logic       rcv_err;

  always #5 clk = ~clk;

  brch_ckpt_queue #(.DEPTH(4), .IDX_W(6), .POS_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .disp_vld(disp_vld), .brch(brch),
    .preg_need(preg_need), .base_indx(base_indx), .curr_pos(curr_pos),
    .cmt_brch(cmt_brch), .cmt_brch_indx(cmt_brch_indx), .mis_pred(mis_pred),
    .brch_mis_indx(brch_mis_indx), .space_ok(space_ok), .count(count),
    .empty(empty), .full(full), .rcv_vld(rcv_vld), .rcv_pos(rcv_pos),
    .rcv_err(rcv_err)
  );

  typedef struct {
    logic       dv;
    logic [3:0] br;
    logic [3:0] nd;
    logic [5:0] bs;
    logic [6:0] cp;
    logic       cm;
    logic [5:0] ci;
    logic       ms;
    logic [5:0] mi;
    logic       sp;
    logic [2:0] cn;
    logic       rv;
    logic [6:0] rp;
    logic       er;
  } vec_t;

  typedef struct {
    logic [2:0] cn;
    logic       rv;
    logic [6:0] rp;
    logic       er;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [6:0] last_rp;

  function automatic vec_t mk(input logic dv, input logic [3:0] br, input logic [3:0] nd,
                              input logic [5:0] bs, input logic [6:0] cp, input logic cm,
                              input logic [5:0] ci, input logic ms, input logic [5:0] mi,
                              input logic sp, input logic [2:0] cn, input logic rv,
                              input logic [6:0] rp, input logic er);
    vec_t v;
    v.dv = dv; v.br = br; v.nd = nd; v.bs = bs; v.cp = cp;
    v.cm = cm; v.ci = ci; v.ms = ms; v.mi = mi;
    v.sp = sp; v.cn = cn; v.rv = rv; v.rp = rp; v.er = er;
    return v;
  endfunction

  function automatic vec_t pushv(input logic [3:0] br, input logic [3:0] nd, input logic [5:0] bs,
                                 input logic [6:0] cp, input logic sp, input logic [2:0] cn,
                                 input logic [6:0] rp);
    return mk(1'b1, br, nd, bs, cp, 1'b0, 6'd0, 1'b0, 6'd0, sp, cn, 1'b0, rp, 1'b0);
  endfunction

  function automatic vec_t cmtv(input logic [5:0] ci, input logic [2:0] cn,
                                input logic [6:0] rp, input logic er);
    return mk(1'b0, 4'b0, 4'b0, 6'd0, 7'h0, 1'b1, ci, 1'b0, 6'd0, 1'b1, cn, 1'b0, rp, er);
  endfunction

  function automatic vec_t misv(input logic [5:0] mi, input logic [2:0] cn, input logic rv,
                                input logic [6:0] rp, input logic er);
    return mk(1'b0, 4'b0, 4'b0, 6'd0, 7'h0, 1'b0, 6'd0, 1'b1, mi, 1'b1, cn, rv, rp, er);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    disp_vld = 1'b0; brch = '0; preg_need = '0; base_indx = '0; curr_pos = '0;
    cmt_brch = 1'b0; cmt_brch_indx = '0; mis_pred = 1'b0; brch_mis_indx = '0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, " count"},   32'(count),   32'(e.cn));
      check({tag, " empty"},   32'(empty),   32'(e.cn == 3'd0));
      check({tag, " full"},    32'(full),    32'(e.cn == 3'd4));
      check({tag, " rcv_vld"}, 32'(rcv_vld), 32'(e.rv));
      check({tag, " rcv_pos"}, 32'(rcv_pos), 32'(e.rp));
      check({tag, " rcv_err"}, 32'(rcv_err), 32'(e.er));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    disp_vld = v.dv; brch = v.br; preg_need = v.nd; base_indx = v.bs; curr_pos = v.cp;
    cmt_brch = v.cm; cmt_brch_indx = v.ci; mis_pred = v.ms; brch_mis_indx = v.mi;
    #1;
    check({tag, " space_ok"}, 32'(space_ok), 32'(v.sp));
    e.cn = v.cn; e.rv = v.rv; e.rp = v.rp; e.er = v.er;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    idleInputs();

    // Dispatch group with a gap and register allocations ahead of the 2nd branch.
    tbl.push_back(pushv(4'b0101, 4'b0011, 6'd62, 7'h7E, 1'b1, 3'd2, 7'h00));
    tbl.push_back(misv(6'd62, 3'd0, 1'b1, 7'h7E, 1'b0));
    tbl.push_back(pushv(4'b0101, 4'b0011, 6'd62, 7'h7E, 1'b1, 3'd2, 7'h7E));
    tbl.push_back(cmtv(6'd62, 3'd1, 7'h7E, 1'b0));
    tbl.push_back(misv(6'd0, 3'd0, 1'b1, 7'h00, 1'b0));
    // Fill, space rejection, in-order commits, commit on empty.
    tbl.push_back(pushv(4'b0001, 4'b0001, 6'd10, 7'h20, 1'b1, 3'd1, 7'h00));
    tbl.push_back(pushv(4'b0010, 4'b0011, 6'd10, 7'h21, 1'b1, 3'd2, 7'h00));
    tbl.push_back(pushv(4'b1000, 4'b0111, 6'd9,  7'h30, 1'b1, 3'd3, 7'h00));
    tbl.push_back(pushv(4'b0011, 4'b0000, 6'd14, 7'h50, 1'b0, 3'd3, 7'h00));
    tbl.push_back(pushv(4'b0001, 4'b0000, 6'd13, 7'h40, 1'b1, 3'd4, 7'h00));
    tbl.push_back(pushv(4'b0001, 4'b0000, 6'd14, 7'h50, 1'b0, 3'd4, 7'h00));
    tbl.push_back(cmtv(6'd10, 3'd3, 7'h00, 1'b0));
    tbl.push_back(cmtv(6'd11, 3'd2, 7'h00, 1'b0));
    tbl.push_back(cmtv(6'd12, 3'd1, 7'h00, 1'b0));
    tbl.push_back(cmtv(6'd13, 3'd0, 7'h00, 1'b0));
    tbl.push_back(cmtv(6'd13, 3'd0, 7'h00, 1'b1));
    // Mispredict the middle of three, then confirm the new tail location.
    tbl.push_back(pushv(4'b0111, 4'b0011, 6'd20, 7'h14, 1'b1, 3'd3, 7'h00));
    tbl.push_back(misv(6'd21, 3'd1, 1'b1, 7'h15, 1'b0));
    tbl.push_back(pushv(4'b0001, 4'b0000, 6'd30, 7'h40, 1'b1, 3'd2, 7'h15));
    tbl.push_back(misv(6'd30, 3'd1, 1'b1, 7'h40, 1'b0));
    tbl.push_back(cmtv(6'd20, 3'd0, 7'h40, 1'b0));
    // Commit head + mispredict 3rd + offered push in one cycle.
    tbl.push_back(pushv(4'b1101, 4'b0110, 6'd40, 7'h60, 1'b1, 3'd3, 7'h40));
    tbl.push_back(mk(1'b1, 4'b0001, 4'b0000, 6'd50, 7'h70, 1'b1, 6'd40, 1'b1, 6'd43,
                     1'b1, 3'd1, 1'b1, 7'h62, 1'b0));
    tbl.push_back(misv(6'd50, 3'd1, 1'b0, 7'h62, 1'b1));
    tbl.push_back(cmtv(6'd42, 3'd0, 7'h62, 1'b0));
    // Commit and mispredict on the same head entry: mispredict wins.
    tbl.push_back(pushv(4'b0011, 4'b0001, 6'd5, 7'h0A, 1'b1, 3'd2, 7'h62));
    tbl.push_back(mk(1'b0, 4'b0, 4'b0, 6'd0, 7'h0, 1'b1, 6'd5, 1'b1, 6'd5,
                     1'b1, 3'd0, 1'b1, 7'h0A, 1'b0));
    // Commit alongside a push.
    tbl.push_back(pushv(4'b0001, 4'b0000, 6'd8, 7'h11, 1'b1, 3'd1, 7'h0A));
    tbl.push_back(mk(1'b1, 4'b0011, 4'b0000, 6'd9, 7'h12, 1'b1, 6'd8, 1'b0, 6'd0,
                     1'b1, 3'd2, 1'b0, 7'h0A, 1'b0));
    tbl.push_back(misv(6'd10, 3'd1, 1'b1, 7'h12, 1'b0));
    tbl.push_back(cmtv(6'd9, 3'd0, 7'h12, 1'b0));
    // Full in one group with index wrap; a same-cycle commit earns no space.
    tbl.push_back(pushv(4'b1111, 4'b1111, 6'd62, 7'h7C, 1'b1, 3'd4, 7'h12));
    tbl.push_back(mk(1'b1, 4'b0001, 4'b0000, 6'd20, 7'h00, 1'b1, 6'd62, 1'b0, 6'd0,
                     1'b0, 3'd3, 1'b0, 7'h12, 1'b0));
    tbl.push_back(misv(6'd0, 3'd1, 1'b1, 7'h7E, 1'b0));
    tbl.push_back(cmtv(6'd63, 3'd0, 7'h7E, 1'b0));

    #12;
    check("reset count",   32'(count),   32'd0);
    check("reset empty",   32'(empty),   32'd1);
    check("reset full",    32'(full),    32'd0);
    check("reset rcv_vld", 32'(rcv_vld), 32'd0);
    check("reset rcv_pos", 32'(rcv_pos), 32'd0);
    check("reset rcv_err", 32'(rcv_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], $sformatf("row%0d", i));
    end
    last_rp = tbl[tbl.size() - 1].rp;

    // Ten two-branch groups: commit the older, mispredict the younger, so head and tail wrap.
    for (int i = 0; i < 10; i++) begin
      logic [5:0] b;
      logic [6:0] p;
      b = 6'(50 + 7 * i);
      p = 7'(5 + 13 * i);
      applyStimulus(pushv(4'b0011, 4'b0001, b, p, 1'b1, 3'd2, last_rp), $sformatf("wrap%0d push", i));
      applyStimulus(cmtv(b, 3'd1, last_rp, 1'b0), $sformatf("wrap%0d cmt", i));
      last_rp = 7'(p + 7'd1);
      applyStimulus(misv(6'(b + 6'd1), 3'd0, 1'b1, last_rp, 1'b0), $sformatf("wrap%0d mis", i));
    end

    // Asynchronous reset between clock edges while a recovery pulse is high.
    applyStimulus(pushv(4'b0011, 4'b0000, 6'd33, 7'h44, 1'b1, 3'd2, last_rp), "arst push");
    applyStimulus(misv(6'd34, 3'd1, 1'b1, 7'h44, 1'b0), "arst mis");
    rst_n = 1'b0;
    idleInputs();
    #1;
    check("arst count",   32'(count),   32'd0);
    check("arst empty",   32'(empty),   32'd1);
    check("arst rcv_vld", 32'(rcv_vld), 32'd0);
    check("arst rcv_pos", 32'(rcv_pos), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(pushv(4'b0001, 4'b0000, 6'd1, 7'h02, 1'b1, 3'd1, 7'h00), "post push");
    applyStimulus(cmtv(6'd1, 3'd0, 7'h00, 1'b0), "post cmt");

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
